// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - eight-digit multiplexed seven-segment scanner with frame-synchronous snapshot
module seg7_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        io_clk,
  input  logic        clr,
  input  logic [31:0] disp_data,
  input  logic [31:0] disp_ctrl,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  // Prescaler is at least one bit wide so SCAN_DIV=1 still elaborates cleanly.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   data_q;
  logic [31:0]   ctrl_q;

  logic          digit_tick;
  logic          frame_wrap;
  logic [3:0]    nibble;
  logic [31:0]   upper_nibbles;
  logic [7:0]    en_mask;
  logic [7:0]    dp_mask;
  logic          blanked;
  logic          visible;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign digit_tick = (presc == PRESC_LAST);
  assign frame_wrap = digit_tick && (idx == 3'd7);

  // Scan timing: prescaler, digit index, frame snapshot and frame pulse.
  always_ff @(posedge io_clk) begin
    if (clr) begin
      presc      <= '0;
      idx        <= 3'd0;
      data_q     <= 32'h0;
      ctrl_q     <= 32'h0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= digit_tick ? '0 : presc + 1'b1;
      frame_tick <= frame_wrap;
      if (digit_tick) begin
        idx <= idx + 3'd1;
      end
      if (frame_wrap) begin
        data_q <= disp_data;
        ctrl_q <= disp_ctrl;
      end
    end
  end

  // Decode the current digit from the snapshot: visibility, blanking, segment pattern.
  always_comb begin
    nibble        = data_q[{idx, 2'b00} +: 4];
    upper_nibbles = data_q >> {idx, 2'b00};
    en_mask       = ctrl_q[15:8];
    dp_mask       = ctrl_q[7:0];
    blanked       = ctrl_q[16] && (idx != 3'd0) && (upper_nibbles == 32'h0);
    visible       = en_mask[idx] && !blanked;
    an_next       = visible ? ~(8'd1 << idx) : 8'hFF;
    dp_next       = !(visible && dp_mask[idx]);
    seg_next      = 7'h7F;
    case (nibble)
      4'h0: seg_next = 7'h40;
      4'h1: seg_next = 7'h79;
      4'h2: seg_next = 7'h24;
      4'h3: seg_next = 7'h30;
      4'h4: seg_next = 7'h19;
      4'h5: seg_next = 7'h12;
      4'h6: seg_next = 7'h02;
      4'h7: seg_next = 7'h78;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h10;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h03;
      4'hC: seg_next = 7'h46;
      4'hD: seg_next = 7'h21;
      4'hE: seg_next = 7'h06;
      4'hF: seg_next = 7'h0E;
      default: seg_next = 7'h7F;
    endcase
  end

  // Register the display drive so the pins are glitch-free; display is dark in reset.
  always_ff @(posedge io_clk) begin
    if (clr) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - scoreboard bench for seg7_scan against a cycle-count reference model
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        io_clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] disp_data = 32'h0;
  logic [31:0] disp_ctrl = 32'h0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan #(.SCAN_DIV(DIV)) dut (
    .io_clk     (io_clk),
    .clr        (clr),
    .disp_data  (disp_data),
    .disp_ctrl  (disp_ctrl),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 io_clk = ~io_clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    int         edge_no;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;
  bit started = 0;
  int edge_count = 0;

  // Reference model state: edges since last reset and the frame contents now showing.
  int          since_rst = 0;
  logic [31:0] shown_data = 32'h0;
  logic [31:0] shown_ctrl = 32'h0;

  // Expected outputs after the coming edge, from the specification's timing rules.
  function automatic exp_t predict(input bit rst, input int n, input logic [31:0] d,
                                   input logic [31:0] c);
    exp_t e;
    int   digit;
    bit   all_zero;
    bit   vis;
    e.edge_no = edge_count;
    if (rst) begin
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
      return e;
    end
    digit = ((n - 1) / DIV) % 8;
    all_zero = 1'b1;
    for (int j = digit; j < 8; j++) begin
      if (((d >> (4 * j)) & 32'hF) != 0) all_zero = 1'b0;
    end
    vis = c[8 + digit] && !(c[16] && digit != 0 && all_zero);
    e.an  = 8'hFF;
    if (vis) e.an[digit] = 1'b0;
    e.seg = hex_tab[(d >> (4 * digit)) & 32'hF];
    e.dp  = !(vis && c[digit]);
    e.ft  = (n % FRAME == 0);
    return e;
  endfunction

  // Drive one cycle of inputs and push the expected response for that edge.
  task automatic step(input logic [31:0] d, input logic [31:0] c, input bit r);
    exp_t e;
    @(negedge io_clk);
    disp_data = d;
    disp_ctrl = c;
    clr = r;
    edge_count++;
    if (r) begin
      e = predict(1'b1, 0, 32'h0, 32'h0);
      since_rst = 0;
      shown_data = 32'h0;
      shown_ctrl = 32'h0;
    end else begin
      since_rst++;
      e = predict(1'b0, since_rst, shown_data, shown_ctrl);
      if (since_rst % FRAME == 0) begin
        shown_data = d;
        shown_ctrl = c;
      end
    end
    exp_q.push_back(e);
    started = 1;
  endtask

  task automatic run(input int cycles, input logic [31:0] d, input logic [31:0] c);
    for (int k = 0; k < cycles; k++) step(d, c, 1'b0);
  endtask

  // Monitor: pop one expectation per edge and compare each output.
  always @(posedge io_clk) begin
    exp_t e;
    #1;
    if (started) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got no expectation, required one per edge");
      end else begin
        e = exp_q.pop_front();
        checks += 3;
        if (an !== e.an) begin
          errors++;
          $display("FAIL an edge %0d: got %h required %h", e.edge_no, an, e.an);
        end
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL seg edge %0d: got %h required %h", e.edge_no, seg, e.seg);
        end
        if (dp !== e.dp) begin
          errors++;
          $display("FAIL dp edge %0d: got %b required %b", e.edge_no, dp, e.dp);
        end
        if (frame_tick !== e.ft) begin
          errors++;
          $display("FAIL frame_tick edge %0d: got %b required %b", e.edge_no, frame_tick, e.ft);
        end
      end
    end
  end

  function automatic logic [31:0] rand_data();
    logic [31:0] v;
    v = $urandom;
    for (int j = 0; j < 8; j++) begin
      if ($urandom_range(1, 0) == 0) v[4*j +: 4] = 4'h0;
    end
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] rc;
    step(32'h0, 32'h0, 1'b1);
    step(32'h0, 32'h0, 1'b1);
    run(2 * FRAME, 32'h12345678, 32'h0000FF00);
    run(2 * FRAME, 32'h00000A05, 32'h0001FF00);
    run(2 * FRAME, 32'h00000000, 32'h0001FF00);
    run(2 * FRAME, 32'h12345678, 32'h0000FF01);
    run(FRAME, 32'h11111111, 32'h0000FF00);
    run(3 * DIV + 1, 32'h11111111, 32'h0000FF00);
    run(2 * FRAME, 32'h22222222, 32'h0000FF00);
    run(2 * FRAME + 5 * DIV + 2, 32'h00000000, 32'h00000000);
    step(32'h0, 32'h0, 1'b1);
    run(2 * FRAME, 32'hDEADBEEF, 32'h0001FFA5);
    rd = rand_data();
    rc = $urandom;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15, 0) == 0) rd = rand_data();
      if ($urandom_range(15, 0) == 0) rc = $urandom;
      step(rd, rc, $urandom_range(299, 0) == 0);
    end
    @(negedge io_clk);
    started = 0;
    @(negedge io_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
